// File: rtl/tlc_pkg.sv
// tlc_pkg: lamp encodings, approach and pre-emption state types shared by the arbiter.
package tlc_pkg;
  typedef logic [2:0] light_t;
  localparam light_t RED = 3'b100, YELLOW = 3'b010, GREEN = 3'b001;
  typedef enum logic [1:0] {M1, M2, MT, S} approach_e;
  typedef enum logic [2:0] {IDLE, CLEAR, ALLRED, SERVE, EXIT, RESYNC} state_e;
  function automatic light_t sanitize(input light_t v);
    return (v == GREEN || v == YELLOW) ? v : RED;
  endfunction
  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way round-robin, first requester at or after ptr (cyclic).
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic       valid
);
  logic [7:0] dbl, spin;
  logic [3:0] rot, pick;
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[3:0];
    pick = rot & (~rot + 4'd1);
    spin = {pick, pick} << ptr;
    grant = spin[7:4];
    valid = |req;
  end
endmodule

// File: rtl/traffic_preempt_arbiter.sv
// traffic_preempt_arbiter: passes controller lights through, or seizes the intersection
// to serve emergency requests round-robin, then hands back with a restart pulse.
module traffic_preempt_arbiter
  import tlc_pkg::*;
#(
  parameter int YELLOW_CYC   = 3,
  parameter int ALLRED_CYC   = 2,
  parameter int HOLD_MIN_CYC = 5,
  parameter int HOLD_MAX_CYC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  light_t     light_M1_in,
  input  light_t     light_M2_in,
  input  light_t     light_MT_in,
  input  light_t     light_S_in,
  input  logic [3:0] emg_req,
  output light_t     light_M1,
  output light_t     light_M2,
  output light_t     light_MT,
  output light_t     light_S,
  output logic [3:0] emg_grant,
  output logic       preempt_active,
  output logic       tlc_restart
);
  localparam int CW = $clog2(HOLD_MAX_CYC + 1);
  state_e state, nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0] gnt, gnt_d, snap, snap_d, busy_now, green_now, pick_req, pick;
  logic [1:0] rr_ptr, rr_d, gidx, pick_ptr;
  logic pick_ok;
  light_t in_l [4];
  light_t lt_d [4];
  light_t lt_q [4];
  // In EXIT the picker looks past the current grant so it cannot be re-served back to back.
  always_comb begin
    in_l = '{sanitize(light_M1_in), sanitize(light_M2_in), sanitize(light_MT_in), sanitize(light_S_in)};
    for (int i = 0; i < 4; i++) begin
      busy_now[i] = in_l[i] != RED;
      green_now[i] = in_l[i] == GREEN;
    end
    gidx = idx_of(gnt);
    pick_req = state == EXIT ? emg_req & ~gnt : emg_req;
    pick_ptr = state == EXIT ? gidx + 2'd1 : rr_ptr;
  end
  rr_pick4 u_pick (.req(pick_req), .ptr(pick_ptr), .grant(pick), .valid(pick_ok));
  always_comb begin
    nxt = state;
    cnt_d = cnt + CW'(1);
    gnt_d = gnt;
    snap_d = snap;
    rr_d = rr_ptr;
    case (state)
      IDLE: begin
        cnt_d = CW'(1);
        if (pick_ok) begin
          gnt_d = pick;
          snap_d = busy_now;
          nxt = |green_now ? CLEAR : ALLRED;
        end
      end
      CLEAR: if (cnt == CW'(YELLOW_CYC)) nxt = ALLRED;
      ALLRED: if (cnt == CW'(ALLRED_CYC)) nxt = |gnt ? SERVE : RESYNC;
      SERVE: if ((cnt >= CW'(HOLD_MIN_CYC) && !(|(emg_req & gnt))) || cnt == CW'(HOLD_MAX_CYC)) nxt = EXIT;
      EXIT: if (cnt == CW'(YELLOW_CYC)) begin
        nxt = ALLRED;
        rr_d = gidx + 2'd1;
        gnt_d = pick_ok ? pick : 4'b0;
      end
      default: nxt = IDLE;
    endcase
    if (nxt != state) cnt_d = CW'(1);
    // Outputs are decoded from next-state values so each register shows the state being entered.
    for (int i = 0; i < 4; i++)
      lt_d[i] = nxt == IDLE ? in_l[i]
              : (nxt == CLEAR && snap_d[i]) || (nxt == EXIT && gnt_d[i]) ? YELLOW
              : nxt == SERVE && gnt_d[i] ? GREEN : RED;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= CW'(1);
      gnt <= '0;
      snap <= '0;
      rr_ptr <= '0;
      lt_q <= '{default: RED};
      emg_grant <= '0;
      preempt_active <= 1'b0;
      tlc_restart <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_d;
      gnt <= gnt_d;
      snap <= snap_d;
      rr_ptr <= rr_d;
      lt_q <= lt_d;
      emg_grant <= (nxt == SERVE || nxt == EXIT) ? gnt_d : 4'b0;
      preempt_active <= nxt != IDLE;
      tlc_restart <= nxt == RESYNC;
    end
  assign light_M1 = lt_q[M1];
  assign light_M2 = lt_q[M2];
  assign light_MT = lt_q[MT];
  assign light_S = lt_q[S];
endmodule
